aes32esi_sched: RTL
===================

# aes32esi_sched

Two-requester scheduler that shares one `aes32esi` byte-step datapath between the key-expansion unit (requester 0) and the round unit (requester 1). For each accepted job it drives four byte-select steps (bs = 0..3) through the datapath, accumulating the result in a register. It returns `init ^ SubWord(word)` to the granted requester over a valid/ready response channel.

## Interface
- `DP_LAT`, default 0: extra wait cycles per step for a registered datapath (0..3); result sampled `DP_LAT` cycles after the step is issued.
- `clk`  in  1  system clock, all logic on rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `req_valid`  in  2  per-requester job request
- `req_ready`  out  2  one-hot accept pulse, at most one bit set
- `req_init0`, `req_init1`  in  32  initial accumulator per requester
- `req_word0`, `req_word1`  in  32  word to substitute per requester
- `dp_rs1`  out  32  accumulator to datapath
- `dp_rs2`  out  32  latched job word to datapath
- `dp_bs`  out  2  byte select to datapath
- `dp_result`  in  32  datapath output; contract: `dp_rs1 ^ (sbox(byte bs of dp_rs2) << 8*bs)`
- `rsp_valid`  out  1  result available
- `rsp_ready`  in  1  consumer accepts result
- `rsp_id`  out  1  requester index of the result
- `rsp_data`  out  32  final accumulator
- `busy`  out  1  high in any state other than IDLE

## Operation
- **States:** IDLE, STEP, WAIT, DONE.
- **IDLE:**
  - If any `req_valid` is set, pick the winner and pulse the winner's `req_ready` for one cycle.
  - Latch the winner's init into `acc`, its word into `word_q`, and its index into `id_q`.
  - Set `bs_q = 0` and go to STEP (or WAIT if `DP_LAT > 0`).
- **WAIT:** count `DP_LAT` cycles while holding `dp_*` stable, then go to STEP.
- **STEP:** set `acc <= dp_result`.
  - If `bs_q == 3`, go to DONE.
  - Otherwise increment `bs_q`, reload the wait counter, and go to WAIT or STEP.
- **DONE:** `rsp_valid = 1` with `rsp_data = acc` and `rsp_id = id_q`. When `rsp_ready` is high, go to IDLE.
- `dp_rs1 = acc`, `dp_rs2 = word_q`, `dp_bs = bs_q` in every state; their values are don't-care outside STEP/WAIT.
- **Arbitration:** see Configuration. No request is accepted outside IDLE; pending requests simply wait.
- Requester inputs are sampled only in the accept cycle. The requester may change them afterwards.
- `bs_q` is a 2-bit counter and never wraps: the FSM exits to DONE at step 3.
- **Reset mid-job:** the job is discarded, no response is produced, and no `req_ready` is issued in the reset cycle.
- All 32-bit arithmetic is XOR only; there is no carry and no truncation.

## Timing
- **Reset values:** `req_ready = 0`, `rsp_valid = 0`, `rsp_id = 0`, `rsp_data = 0`, `busy = 0`, `dp_bs = 0`, `dp_rs1 = 0`, `dp_rs2 = 0`; state is IDLE; RR pointer favours requester 0.
- **Accept:** `req_ready` is asserted combinationally in IDLE in the same cycle as `req_valid` (cycle T).
- **Latency:** `rsp_valid` first rises at T + 1 + 4·(1 + DP_LAT). With `DP_LAT = 0` that is T+5.
- `rsp_valid`, `rsp_data` and `rsp_id` are held stable until the handshake completes. Backpressure may last any number of cycles.
- **Throughput:** the earliest next accept is the cycle after the response handshake. Maximum rate is one job per 6 cycles at `DP_LAT = 0`.
- **Simultaneous requests:** exactly one is granted; the loser keeps `req_valid` asserted and is served next.

## Configuration
- `AES32ESI_SCHED_RR_EN` defined: round-robin arbitration. The pointer toggles to the non-winner after each accept, so two continuously requesting masters alternate 0,1,0,1.
- `AES32ESI_SCHED_RR_EN` undefined: fixed priority, requester 0 always wins. The RR pointer logic is removed.

## Test plan
- **Zero word, single request:** after reset, requester 0 with init 0x00000000 and word 0x00000000 → accept at T; `dp_bs` sequence 0,1,2,3 over T+1..T+4; `rsp_valid` at T+5 with `rsp_data = 0x63636363`, `rsp_id = 0`.
- **Mixed bytes:** requester 1 with init 0xFFFFFFFF and word 0x01005300 → `rsp_data = 0x839C129C`, `rsp_id = 1`.
- **Contention, RR build:** both requesters held valid for 4 jobs → grants 0,1,0,1. Non-RR build → grants 0,0,0,0, and requester 1 is never served.
- **Backpressure:** `rsp_ready = 0` for 10 cycles → `rsp_valid`, `rsp_data` and `rsp_id` stay constant, no `req_ready` is issued, and the next accept comes the cycle after `rsp_ready = 1`.
- **`DP_LAT = 2`:** word 0x00000000 → each `dp_bs` value is held 3 cycles; `rsp_valid` at T+13 with 0x63636363.
- **Reset mid-job:** `rst_n = 0` at T+2 for 1 cycle → all outputs return to reset values, no response appears, and a new request after reset completes normally.

Source files
------------

// File: rtl/aes32esi_sched.sv
// Two-requester scheduler sharing one aes32esi byte-step datapath; four steps per job, result = init ^ SubWord(word).
// Define AES32ESI_SCHED_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module aes32esi_sched #(
  parameter int DP_LAT = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [31:0] req_init0,
  input  logic [31:0] req_init1,
  input  logic [31:0] req_word0,
  input  logic [31:0] req_word1,
  output logic [31:0] dp_rs1,
  output logic [31:0] dp_rs2,
  output logic [1:0]  dp_bs,
  input  logic [31:0] dp_result,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_data,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, STEP, WAIT, DONE} state_t;

  localparam logic [1:0] LAT = 2'(DP_LAT);

  state_t      state_q;
  logic [31:0] acc_q;
  logic [31:0] word_q;
  logic [1:0]  bs_q;
  logic [1:0]  wcnt_q;
  logic        id_q;

  logic        winner;
  logic        grant;
  logic [31:0] init_d;
  logic [31:0] word_d;

`ifdef AES32ESI_SCHED_RR_EN
  logic rr_q;

  // On contention the pointer names the winner; a lone request always wins.
  always_comb winner = (req_valid == 2'b11) ? rr_q : ~req_valid[0];
`else
  always_comb winner = ~req_valid[0];
`endif

  always_comb begin
    grant     = rst_n && (state_q == IDLE) && (req_valid != 2'b00);
    req_ready = 2'b00;
    if (grant) req_ready = winner ? 2'b10 : 2'b01;
    init_d    = winner ? req_init1 : req_init0;
    word_d    = winner ? req_word1 : req_word0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      word_q  <= '0;
      bs_q    <= '0;
      wcnt_q  <= '0;
      id_q    <= 1'b0;
`ifdef AES32ESI_SCHED_RR_EN
      rr_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (grant) begin
            acc_q   <= init_d;
            word_q  <= word_d;
            id_q    <= winner;
            bs_q    <= 2'd0;
            wcnt_q  <= LAT;
            state_q <= (LAT != 2'd0) ? WAIT : STEP;
`ifdef AES32ESI_SCHED_RR_EN
            rr_q    <= ~winner;
`endif
          end
        end
        // dp_* stay frozen here so a registered datapath sees stable operands.
        WAIT: begin
          if (wcnt_q <= 2'd1) state_q <= STEP;
          else                wcnt_q  <= wcnt_q - 2'd1;
        end
        STEP: begin
          acc_q <= dp_result;
          if (bs_q == 2'd3) begin
            state_q <= DONE;
          end else begin
            bs_q    <= bs_q + 2'd1;
            wcnt_q  <= LAT;
            state_q <= (LAT != 2'd0) ? WAIT : STEP;
          end
        end
        DONE: begin
          if (rsp_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    dp_rs1    = acc_q;
    dp_rs2    = word_q;
    dp_bs     = bs_q;
    rsp_valid = (state_q == DONE);
    rsp_data  = acc_q;
    rsp_id    = id_q;
    busy      = (state_q != IDLE);
  end

endmodule
